// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared encodings and defaults for the MEM pipeline stage.
//   BranchType codes : BR_NONE, BR_BEQ, BR_BNE, BR_BLTZ
//   DBDataSrc codes  : WB_SRC_ALU, WB_SRC_MEM, WB_SRC_PC4 (code 3 also selects ALU)
//   DMEM_BYTES_DEF   : default data RAM size in bytes
package mem_stage_pkg;

  localparam logic [1:0] BR_NONE = 2'd0;
  localparam logic [1:0] BR_BEQ  = 2'd1;
  localparam logic [1:0] BR_BNE  = 2'd2;
  localparam logic [1:0] BR_BLTZ = 2'd3;

  localparam logic [1:0] WB_SRC_ALU = 2'd0;
  localparam logic [1:0] WB_SRC_MEM = 2'd1;
  localparam logic [1:0] WB_SRC_PC4 = 2'd2;

  localparam int DMEM_BYTES_DEF = 128;

endpackage

// File: rtl/mem_stage_data_ram.sv
// data_ram: byte-organised data memory, big-endian word view.
//   clk   : write clock, rising edge
//   we    : write all four bytes of wdata at addr on the rising edge
//   addr  : byte address; the four byte indices wrap modulo DMEM_BYTES
//   wdata : word to store, MSB byte lands at addr
//   rdata : combinational word read {M[a], M[a+1], M[a+2], M[a+3]}
// Contents are never reset.
module data_ram
  import mem_stage_pkg::*;
#(
  parameter int DMEM_BYTES = DMEM_BYTES_DEF,
  parameter int ADDR_W     = $clog2(DMEM_BYTES)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [7:0] mem [DMEM_BYTES];

  // Adding in ADDR_W bits gives the modulo wrap for free.
  logic [ADDR_W-1:0] a0, a1, a2, a3;
  assign a0 = addr;
  assign a1 = addr + ADDR_W'(1);
  assign a2 = addr + ADDR_W'(2);
  assign a3 = addr + ADDR_W'(3);

  // Read is pre-edge, so a same-cycle store/load to one address returns old data.
  assign rdata = {mem[a0], mem[a1], mem[a2], mem[a3]};

  always_ff @(posedge clk) begin
    if (we) begin
      mem[a0] <= wdata[31:24];
      mem[a1] <= wdata[23:16];
      mem[a2] <= wdata[15:8];
      mem[a3] <= wdata[7:0];
    end
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the 5-stage pipeline.
//   Inputs : EX/MEM register outputs (MEM_*), Clk, Reset (synchronous, active-low)
//   Outputs: BranchTaken/BranchTarget/Flush (combinational redirect),
//            MEM_FwdData (combinational write-back value for EX forwarding),
//            WB_RegWre/WB_WriteReg/WB_WriteData (MEM/WB register).
// Optional build macro MEM_ALIGN_CHECK_EN adds the registered MisalignErr output;
// misaligned word accesses then neither store nor return load data.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DMEM_BYTES = DMEM_BYTES_DEF,
  parameter int ADDR_W     = $clog2(DMEM_BYTES)
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MEM_MemWre,
  input  logic        MEM_MemRead,
  input  logic [1:0]  MEM_BranchType,
  input  logic [1:0]  MEM_DBDataSrc,
  input  logic        MEM_RegWre,
  input  logic [31:0] MEM_PCadd4,
  input  logic [31:0] MEM_BranchPC,
  input  logic        MEM_Zero,
  input  logic        MEM_Sign,
  input  logic [31:0] MEM_DataIn,
  input  logic [31:0] MEM_ALUResult,
  input  logic [4:0]  MEM_WriteReg,
  output logic        BranchTaken,
  output logic [31:0] BranchTarget,
  output logic        Flush,
  output logic [31:0] MEM_FwdData,
  output logic        WB_RegWre,
  output logic [4:0]  WB_WriteReg,
  output logic [31:0] WB_WriteData
`ifdef MEM_ALIGN_CHECK_EN
  , output logic      MisalignErr
`endif
);

  logic        misalign;
  logic        ram_we;
  logic [31:0] ram_rdata;
  logic [31:0] load_data;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = (MEM_MemRead | MEM_MemWre) & (MEM_ALUResult[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // Reset low discards the in-flight instruction, including its store.
  assign ram_we    = MEM_MemWre & Reset & ~misalign;
  assign load_data = (MEM_MemRead & ~misalign) ? ram_rdata : 32'h0;

  data_ram #(
    .DMEM_BYTES (DMEM_BYTES),
    .ADDR_W     (ADDR_W)
  ) u_ram (
    .clk   (Clk),
    .we    (ram_we),
    .addr  (MEM_ALUResult[ADDR_W-1:0]),
    .wdata (MEM_DataIn),
    .rdata (ram_rdata)
  );

  always_comb begin
    BranchTaken = 1'b0;
    case (MEM_BranchType)
      BR_BEQ:  BranchTaken = MEM_Zero;
      BR_BNE:  BranchTaken = ~MEM_Zero;
      BR_BLTZ: BranchTaken = MEM_Sign;
      default: BranchTaken = 1'b0;
    endcase
  end

  // Flush targets the younger stages only; this instruction still completes.
  assign Flush        = BranchTaken;
  assign BranchTarget = MEM_BranchPC;

  always_comb begin
    MEM_FwdData = MEM_ALUResult;
    case (MEM_DBDataSrc)
      WB_SRC_MEM: MEM_FwdData = load_data;
      WB_SRC_PC4: MEM_FwdData = MEM_PCadd4;
      default:    MEM_FwdData = MEM_ALUResult;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      WB_RegWre    <= 1'b0;
      WB_WriteReg  <= 5'd0;
      WB_WriteData <= 32'h0;
    end else begin
      WB_RegWre    <= MEM_RegWre;
      WB_WriteReg  <= MEM_WriteReg;
      WB_WriteData <= MEM_FwdData;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge Clk) begin
    if (!Reset) MisalignErr <= 1'b0;
    else        MisalignErr <= misalign;
  end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage against a byte-array reference model.
module tb_mem_stage;

  localparam int NB = 128;

`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset;
  logic        MEM_MemWre, MEM_MemRead, MEM_RegWre, MEM_Zero, MEM_Sign;
  logic [1:0]  MEM_BranchType, MEM_DBDataSrc;
  logic [31:0] MEM_PCadd4, MEM_BranchPC, MEM_DataIn, MEM_ALUResult;
  logic [4:0]  MEM_WriteReg;
  logic        BranchTaken, Flush, WB_RegWre;
  logic [31:0] BranchTarget, MEM_FwdData, WB_WriteData;
  logic [4:0]  WB_WriteReg;
`ifdef MEM_ALIGN_CHECK_EN
  logic        MisalignErr;
`endif

  mem_stage #(.DMEM_BYTES(NB)) u_dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .MEM_MemWre     (MEM_MemWre),
    .MEM_MemRead    (MEM_MemRead),
    .MEM_BranchType (MEM_BranchType),
    .MEM_DBDataSrc  (MEM_DBDataSrc),
    .MEM_RegWre     (MEM_RegWre),
    .MEM_PCadd4     (MEM_PCadd4),
    .MEM_BranchPC   (MEM_BranchPC),
    .MEM_Zero       (MEM_Zero),
    .MEM_Sign       (MEM_Sign),
    .MEM_DataIn     (MEM_DataIn),
    .MEM_ALUResult  (MEM_ALUResult),
    .MEM_WriteReg   (MEM_WriteReg),
    .BranchTaken    (BranchTaken),
    .BranchTarget   (BranchTarget),
    .Flush          (Flush),
    .MEM_FwdData    (MEM_FwdData),
    .WB_RegWre      (WB_RegWre),
    .WB_WriteReg    (WB_WriteReg),
    .WB_WriteData   (WB_WriteData)
`ifdef MEM_ALIGN_CHECK_EN
    , .MisalignErr  (MisalignErr)
`endif
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference memory: plain byte array, word access by modulo index arithmetic.
  byte unsigned ref_mem [NB];

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] w;
    w = 32'h0;
    for (int k = 0; k < 4; k++)
      w = (w << 8) | 32'(ref_mem[(a + k) % NB]);
    return w;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [31:0] d);
    for (int k = 0; k < 4; k++)
      ref_mem[(a + k) % NB] = d[31 - 8*k -: 8];
  endtask

  // One pipeline cycle: apply inputs, check combinational outputs, clock, check WB.
  task automatic run(input bit rst, input bit wre, input bit rd, input logic [1:0] bt,
                     input logic [1:0] src, input bit regwre, input logic [31:0] pc4,
                     input logic [31:0] bpc, input bit z, input bit s,
                     input logic [31:0] din, input logic [31:0] alu, input logic [4:0] wr);
    bit          exp_mis, exp_taken;
    logic [31:0] exp_rd, exp_fwd;
    Reset = rst; MEM_MemWre = wre; MEM_MemRead = rd; MEM_BranchType = bt;
    MEM_DBDataSrc = src; MEM_RegWre = regwre; MEM_PCadd4 = pc4; MEM_BranchPC = bpc;
    MEM_Zero = z; MEM_Sign = s; MEM_DataIn = din; MEM_ALUResult = alu; MEM_WriteReg = wr;
    #1;
    exp_mis   = ALIGN_EN && (rd || wre) && (alu % 4 != 0);
    exp_rd    = (rd && !exp_mis) ? ref_word(alu) : 32'h0;
    exp_fwd   = (src == 2'd1) ? exp_rd : (src == 2'd2) ? pc4 : alu;
    exp_taken = (bt == 2'd1 && z) || (bt == 2'd2 && !z) || (bt == 2'd3 && s);
    check("BranchTaken", 32'(BranchTaken), 32'(exp_taken));
    check("Flush", 32'(Flush), 32'(exp_taken));
    check("BranchTarget", BranchTarget, bpc);
    check("MEM_FwdData", MEM_FwdData, exp_fwd);
    @(posedge Clk);
    #1;
    if (rst && wre && !exp_mis) ref_store(alu, din);
    check("WB_RegWre", 32'(WB_RegWre), rst ? 32'(regwre) : 32'h0);
    check("WB_WriteReg", 32'(WB_WriteReg), rst ? 32'(wr) : 32'h0);
    check("WB_WriteData", WB_WriteData, rst ? exp_fwd : 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
    check("MisalignErr", 32'(MisalignErr), 32'(rst && exp_mis));
`endif
  endtask

  task automatic peek(input string tag, input int idx);
    check(tag, 32'(u_dut.u_ram.mem[idx]), 32'(ref_mem[idx]));
  endtask

  initial begin
    // 1. Reset held two edges with a live write-back request, then released.
    run(0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 5'd5);
    run(0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 5'd5);
    run(1, 0, 0, 0, 0, 1, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 5'd5);

    // Fill every byte with known data via aligned word stores.
    for (int i = 0; i < NB / 4; i++)
      run(1, 1, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, $urandom, 32'(i * 4), 5'd0);

    // 2. Store then load address 8; byte peek of MSB.
    run(1, 1, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h12345678, 32'd8, 5'd0);
    check("peek_m8_const", 32'(u_dut.u_ram.mem[8]), 32'h12);
    run(1, 0, 1, 0, 1, 1, 32'h0, 32'h0, 0, 0, 32'h0, 32'd8, 5'd3);
    check("load8_const", WB_WriteData, 32'h12345678);

    // 3. Branch conditions.
    run(1, 0, 0, 1, 0, 0, 32'h0, 32'hCAFE0000, 1, 0, 32'h0, 32'h0, 5'd0);
    run(1, 0, 0, 2, 0, 0, 32'h0, 32'hCAFE0004, 1, 0, 32'h0, 32'h0, 5'd0);
    run(1, 0, 0, 3, 0, 0, 32'h0, 32'hCAFE0008, 0, 1, 32'h0, 32'h0, 5'd0);
    run(1, 0, 0, 0, 0, 0, 32'h0, 32'hCAFE000C, 1, 1, 32'h0, 32'h0, 5'd0);

    // 4. Link value, then a wrapping store at the top of memory.
    run(1, 0, 0, 0, 2, 1, 32'h00000040, 32'h0, 0, 0, 32'h0, 32'h0, 5'd31);
    run(1, 1, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'hAABBCCDD, 32'h1000007E, 5'd0);
    peek("wrap_m126", 126);
    peek("wrap_m127", 127);
    peek("wrap_m0", 0);
    peek("wrap_m1", 1);
    if (!ALIGN_EN) check("wrap_m0_const", 32'(u_dut.u_ram.mem[0]), 32'hCC);

    // 5. Store under reset is dropped; following load returns prior contents.
    run(0, 1, 0, 0, 0, 1, 32'h0, 32'h0, 0, 0, 32'hFFFFFFFF, 32'd4, 5'd7);
    run(1, 0, 1, 0, 1, 1, 32'h0, 32'h0, 0, 0, 32'h0, 32'd4, 5'd7);

    // 6. Unaligned store at 6, then aligned access clears the flag.
    run(1, 1, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h55AA55AA, 32'd6, 5'd0);
    run(1, 0, 1, 0, 1, 1, 32'h0, 32'h0, 0, 0, 32'h0, 32'd4, 5'd2);
    run(1, 0, 1, 0, 1, 1, 32'h0, 32'h0, 0, 0, 32'h0, 32'd8, 5'd2);

    // Randomized traffic, including same-cycle store/load and occasional reset.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] alu;
      alu = $urandom;
      if ($urandom_range(0, 3) == 0) alu = {alu[31:7], 7'(4 * $urandom_range(0, 3))};
      run($urandom_range(0, 15) != 0, 1'($urandom), 1'($urandom), 2'($urandom),
          2'($urandom), 1'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom),
          $urandom, alu, 5'($urandom));
    end

    for (int i = 0; i < NB; i++) peek("final_mem", i);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
